pong_match_controller: RTL and testbench

Match-level sequencer for the pong game engine, clocked on the VGA pixel clock.
- Owns the game state, both scores, the serve delay and the post-point hold.
- Gates ball motion in the game engine via BALL_ENABLE and issues a one-cycle SERVE pulse with a direction.
- Consumes per-side miss pulses from the ball logic and a once-per-frame tick from VGA timing.

---
 rtl/pong_match_if.sv | 26 ++
 rtl/pong_match_controller.sv | 147 ++++++++++++++
 tb/tb_pong_match_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_if.sv
// Signal bundle between the pong game engine (master) and the match controller (slave).
interface pong_match_if;
  logic       FRAME_TICK;
  logic       START;
  logic       PAUSE;
  logic       MISS_A;
  logic       MISS_B;
  logic       BALL_ENABLE;
  logic       SERVE;
  logic       SERVE_DIR;
  logic [3:0] SCORE_A;
  logic [3:0] SCORE_B;
  logic       GAME_OVER;
  logic       WINNER;
  logic [2:0] STATE;

  modport master (
    output FRAME_TICK, START, PAUSE, MISS_A, MISS_B,
    input  BALL_ENABLE, SERVE, SERVE_DIR, SCORE_A, SCORE_B, GAME_OVER, WINNER, STATE
  );

  modport slave (
    input  FRAME_TICK, START, PAUSE, MISS_A, MISS_B,
    output BALL_ENABLE, SERVE, SERVE_DIR, SCORE_A, SCORE_B, GAME_OVER, WINNER, STATE
  );
endinterface

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve delay, rally, point hold, scoring and game over.
// Optional pause support is compiled in with `define PONG_MATCH_PAUSE_EN.
module pong_match_controller #(
  parameter int SERVE_FRAMES = 120,
  parameter int POINT_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic         VGA_CLOCK,
  input  logic         RESET_N,
  pong_match_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SERVE_WAIT = 3'd1,
    S_PLAY       = 3'd2,
    S_POINT      = 3'd3,
    S_GAME_OVER  = 3'd4,
    S_PAUSED     = 3'd5
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_frame_cnt, w_frame_cnt_nxt;
  logic [3:0] r_score_a, w_score_a_nxt;
  logic [3:0] r_score_b, w_score_b_nxt;
  logic       r_serve, w_serve_nxt;
  logic       r_serve_dir, w_serve_dir_nxt;
  logic       r_winner, w_winner_nxt;
  logic       r_ball_en, r_game_over, r_start_q;
  logic       w_start_evt, w_pause_req;

  assign w_start_evt = bus.START & ~r_start_q;

`ifdef PONG_MATCH_PAUSE_EN
  assign w_pause_req = bus.PAUSE;
`else
  assign w_pause_req = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_score_a_nxt   = r_score_a;
    w_score_b_nxt   = r_score_b;
    w_serve_nxt     = 1'b0;
    w_serve_dir_nxt = r_serve_dir;
    w_winner_nxt    = r_winner;

    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (w_start_evt) begin
          w_score_a_nxt   = 4'd0;
          w_score_b_nxt   = 4'd0;
          w_serve_dir_nxt = 1'b1;
          w_state_nxt     = S_SERVE_WAIT;
        end
      end
      S_SERVE_WAIT: begin
        if (bus.FRAME_TICK) begin
          if (r_frame_cnt == SERVE_LAST) begin
            w_state_nxt = S_PLAY;
            w_serve_nxt = 1'b1;
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end
      S_PLAY: begin
        // A simultaneous double miss is a dead ball: point hold, no score.
        if (bus.MISS_A || bus.MISS_B) begin
          w_state_nxt = S_POINT;
          if (bus.MISS_A && !bus.MISS_B) begin
            if (r_score_b != WIN) w_score_b_nxt = r_score_b + 4'd1;
            w_serve_dir_nxt = 1'b0;
          end else if (bus.MISS_B && !bus.MISS_A) begin
            if (r_score_a != WIN) w_score_a_nxt = r_score_a + 4'd1;
            w_serve_dir_nxt = 1'b1;
          end
        end else if (w_pause_req) begin
          w_state_nxt = S_PAUSED;
        end
      end
      S_POINT: begin
        if (bus.FRAME_TICK) begin
          if (r_frame_cnt == POINT_LAST) begin
            if (r_score_a == WIN || r_score_b == WIN) begin
              w_state_nxt  = S_GAME_OVER;
              w_winner_nxt = (r_score_b == WIN);
            end else begin
              w_state_nxt = S_SERVE_WAIT;
            end
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end
      S_PAUSED: begin
        if (w_pause_req) w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt != r_state) w_frame_cnt_nxt = 8'd0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= 8'd0;
      r_score_a   <= 4'd0;
      r_score_b   <= 4'd0;
      r_serve     <= 1'b0;
      r_serve_dir <= 1'b1;
      r_winner    <= 1'b0;
      r_ball_en   <= 1'b0;
      r_game_over <= 1'b0;
      r_start_q   <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_score_a   <= w_score_a_nxt;
      r_score_b   <= w_score_b_nxt;
      r_serve     <= w_serve_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_winner    <= w_winner_nxt;
      r_ball_en   <= (w_state_nxt == S_PLAY);
      r_game_over <= (w_state_nxt == S_GAME_OVER);
      r_start_q   <= bus.START;
    end
  end

  assign bus.STATE       = r_state;
  assign bus.SCORE_A     = r_score_a;
  assign bus.SCORE_B     = r_score_b;
  assign bus.SERVE       = r_serve;
  assign bus.SERVE_DIR   = r_serve_dir;
  assign bus.WINNER      = r_winner;
  assign bus.BALL_ENABLE = r_ball_en;
  assign bus.GAME_OVER   = r_game_over;

endmodule

// File: tb/tb_pong_match_controller.sv
// Self-checking bench: directed match scenarios plus random play against a match model.
module tb_pong_match_controller;

  localparam int SERVE_FRAMES = 3;
  localparam int POINT_FRAMES = 2;
  localparam int WIN_SCORE    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  pong_match_if bus ();

  pong_match_controller #(
    .SERVE_FRAMES(SERVE_FRAMES),
    .POINT_FRAMES(POINT_FRAMES),
    .WIN_SCORE   (WIN_SCORE)
  ) dut (
    .VGA_CLOCK(clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Match model: plain integers describing where the match stands.
  int m_state = 0;
  int m_sa = 0;
  int m_sb = 0;
  int m_frames = 0;
  bit m_dir = 1'b1;
  bit m_serve = 1'b0;
  bit m_win = 1'b0;
  bit m_start_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_sa = 0; m_sb = 0; m_frames = 0;
    m_dir = 1'b1; m_serve = 1'b0; m_win = 1'b0; m_start_prev = 1'b1;
  endtask

  task automatic new_match();
    m_sa = 0; m_sb = 0; m_dir = 1'b1; m_state = 1;
  endtask

  task automatic model_step();
    bit evt;
    bit pause_on;
    int prev;
    evt = bus.START && !m_start_prev;
    m_start_prev = bus.START;
    prev = m_state;
    m_serve = 1'b0;
`ifdef PONG_MATCH_PAUSE_EN
    pause_on = bus.PAUSE;
`else
    pause_on = 1'b0;
`endif
    case (m_state)
      0, 4: if (evt) new_match();
      1: if (bus.FRAME_TICK) begin
           if (m_frames + 1 == SERVE_FRAMES) begin m_state = 2; m_serve = 1'b1; end
           else m_frames++;
         end
      2: if (bus.MISS_A || bus.MISS_B) begin
           m_state = 3;
           if (bus.MISS_A && !bus.MISS_B) begin
             if (m_sb < WIN_SCORE) m_sb++;
             m_dir = 1'b0;
           end else if (bus.MISS_B && !bus.MISS_A) begin
             if (m_sa < WIN_SCORE) m_sa++;
             m_dir = 1'b1;
           end
         end else if (pause_on) m_state = 5;
      3: if (bus.FRAME_TICK) begin
           if (m_frames + 1 == POINT_FRAMES) begin
             if (m_sa == WIN_SCORE || m_sb == WIN_SCORE) begin
               m_state = 4; m_win = (m_sb == WIN_SCORE);
             end else m_state = 1;
           end else m_frames++;
         end
      5: if (pause_on) m_state = 2;
      default: m_state = 0;
    endcase
    if (m_state != prev) m_frames = 0;
  endtask

  // One clock with the given inputs; outputs are settled on return.
  task automatic drive(input bit ft, input bit st, input bit pa, input bit ma, input bit mb);
    bus.FRAME_TICK = ft; bus.START = st; bus.PAUSE = pa; bus.MISS_A = ma; bus.MISS_B = mb;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("state",   bus.STATE,       m_state);
      check("score_a", bus.SCORE_A,     m_sa);
      check("score_b", bus.SCORE_B,     m_sb);
      check("serve",   bus.SERVE,       m_serve);
      check("dir",     bus.SERVE_DIR,   m_dir);
      check("ball_en", bus.BALL_ENABLE, (m_state == 2));
      check("over",    bus.GAME_OVER,   (m_state == 4));
      if (m_state == 4) check("winner", bus.WINNER, m_win);
    end
  end

  initial begin
    bus.FRAME_TICK = 1'b0; bus.START = 1'b0; bus.PAUSE = 1'b0;
    bus.MISS_A = 1'b0; bus.MISS_B = 1'b0;
    model_reset();
    repeat (3) drive(0, 0, 0, 0, 0);
    check("rst_state", bus.STATE, 0);
    check("rst_dir",   bus.SERVE_DIR, 1);
    check("rst_serve", bus.SERVE, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);

    // Start, serve delay, first serve.
    drive(0, 1, 0, 0, 0);
    check("t1_sw", bus.STATE, 1);
    ticks(2);
    check("t1_still_sw", bus.STATE, 1);
    ticks(1);
    check("t1_play", bus.STATE, 2);
    check("t1_serve", bus.SERVE, 1);
    check("t1_dir", bus.SERVE_DIR, 1);
    check("t1_ball", bus.BALL_ENABLE, 1);
    drive(0, 0, 0, 0, 0);
    check("t1_serve_pulse", bus.SERVE, 0);

    // A scores.
    drive(0, 0, 0, 0, 1);
    check("t2_sa", bus.SCORE_A, 1);
    check("t2_point", bus.STATE, 3);
    check("t2_ball", bus.BALL_ENABLE, 0);
    ticks(2);
    check("t2_sw", bus.STATE, 1);
    ticks(3);
    check("t2_serve", bus.SERVE, 1);
    check("t2_dir", bus.SERVE_DIR, 1);

    // B scores twice and wins.
    drive(0, 0, 0, 1, 0);
    check("t3_sb1", bus.SCORE_B, 1);
    check("t3_dir", bus.SERVE_DIR, 0);
    ticks(5);
    check("t3_serve_dir0", bus.SERVE_DIR, 0);
    check("t3_play", bus.STATE, 2);
    drive(0, 0, 0, 1, 0);
    check("t3_sb2", bus.SCORE_B, 2);
    ticks(2);
    check("t3_over_state", bus.STATE, 4);
    check("t3_over", bus.GAME_OVER, 1);
    check("t3_winner", bus.WINNER, 1);
    drive(0, 1, 0, 0, 0);
    check("t3_restart", bus.STATE, 1);
    check("t3_clr_b", bus.SCORE_B, 0);
    drive(0, 0, 0, 0, 0);

    // Double miss is a dead ball.
    ticks(3);
    drive(0, 0, 0, 1, 1);
    check("t4_point", bus.STATE, 3);
    check("t4_sa", bus.SCORE_A, 0);
    check("t4_sb", bus.SCORE_B, 0);
    check("t4_dir", bus.SERVE_DIR, 1);
    ticks(5);
    check("t4_play", bus.STATE, 2);

    // Reset mid-PLAY with START held, then held START through release.
    drive(0, 1, 0, 0, 0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_rst_state", bus.STATE, 0);
    check("t5_rst_serve", bus.SERVE, 0);
    check("t5_rst_ball", bus.BALL_ENABLE, 0);
    check("t5_rst_sa", bus.SCORE_A, 0);
    drive(0, 1, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("t5_held", bus.STATE, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("t5_start", bus.STATE, 1);

`ifdef PONG_MATCH_PAUSE_EN
    ticks(3);
    drive(0, 0, 1, 0, 0);
    check("t6_paused", bus.STATE, 5);
    check("t6_ball", bus.BALL_ENABLE, 0);
    drive(1, 0, 0, 1, 0);
    check("t6_ignore_miss", bus.SCORE_B, 0);
    check("t6_still", bus.STATE, 5);
    drive(0, 0, 1, 0, 0);
    check("t6_resume", bus.STATE, 2);
    check("t6_ball_on", bus.BALL_ENABLE, 1);
    check("t6_no_serve", bus.SERVE, 0);
`endif

    // Random play; the compare process checks every cycle against the model.
    begin
      bit st;
      st = bus.START;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(7) == 0) st = ~st;
        drive($urandom_range(2) == 0, st, $urandom_range(15) == 0,
              $urandom_range(19) == 0, $urandom_range(19) == 0);
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
